// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg
// Shared constants and helpers for the scanned seven-segment driver.
//   HEX_PAT        : 16-entry nibble -> segment table, active-high, bit order gfedcba
//   SEG_OFF_H      : all segments dark, active-high form
//   seg_polarity() : converts an active-high pattern to the pin level
package seven_seg_pkg;

  // Entry n holds the pattern for nibble value n (entry 0 is the rightmost slice).
  localparam logic [15:0][6:0] HEX_PAT = {
    7'h71, 7'h79, 7'h5E, 7'h39,   // F E d C
    7'h7C, 7'h77, 7'h6F, 7'h7F,   // b A 9 8
    7'h07, 7'h7D, 7'h6D, 7'h66,   // 7 6 5 4
    7'h4F, 7'h5B, 7'h06, 7'h3F    // 3 2 1 0
  };

  localparam logic [6:0] SEG_OFF_H = 7'h00;

  function automatic logic [6:0] seg_polarity(input logic [6:0] pat_h, input logic active_low);
    return active_low ? ~pat_h : pat_h;
  endfunction

endpackage

// File: rtl/seven_seg_hex.sv
// seven_seg_hex
// Combinational hex nibble to seven-segment decoder.
//   nib : 4-bit hex value
//   pat : 7-bit segment pattern, active-high, gfedcba
module seven_seg_hex
  import seven_seg_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] pat
);

  assign pat = HEX_PAT[nib];

endmodule

// File: rtl/seven_seg_scan.sv
// seven_seg_scan
// Time-multiplexed driver for a NUM_DIGITS seven-segment display. A shadow
// register holds the digits being shown so multi-digit updates land atomically.
//   clk, rst   : system clock, asynchronous active-high reset
//   data       : hex nibbles, digit 0 in [3:0] (rightmost)
//   dp, blank  : per-digit decimal point request and forced dark
//   lz_en      : leading-zero suppression enable (used live, not shadowed)
//   load       : capture data/dp/blank into the shadow
//   seg, dp_out: segment and decimal point pins (SEG_ACTIVE_LOW polarity)
//   an         : digit enables (AN_ACTIVE_LOW polarity)
//   frame_done : one-cycle pulse after the last digit's dwell ends
module seven_seg_scan
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int CLK_HZ         = 50_000_000,
  parameter int SCAN_HZ        = 1000,
  parameter int GUARD          = 16,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] data,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   blank,
  input  logic                    lz_en,
  input  logic                    load,
  output logic [6:0]              seg,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int DIV = CLK_HZ / SCAN_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  generate
    if (DIV < GUARD + 2) begin : g_bad_div
      $error("seven_seg_scan: CLK_HZ/SCAN_HZ must be at least GUARD+2");
    end
    if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_digits
      $error("seven_seg_scan: NUM_DIGITS must be in 1..8");
    end
  endgenerate

  logic [PW-1:0]           pcnt;
  logic [IW-1:0]           idx;
  logic                    tick;
  logic                    last_digit;
  logic                    in_guard;

  logic [4*NUM_DIGITS-1:0] sh_data;
  logic [NUM_DIGITS-1:0]   sh_dp;
  logic [NUM_DIGITS-1:0]   sh_blank;

  logic [NUM_DIGITS-1:0]   dark;
  logic                    lz_run;

  logic [3:0]              cur_nib;
  logic                    cur_dp;
  logic                    cur_dark;
  logic [6:0]              cur_pat;
  logic [NUM_DIGITS-1:0]   an_sel;

  logic [6:0]              seg_h_nxt;
  logic                    dp_h_nxt;
  logic [NUM_DIGITS-1:0]   an_h_nxt;

  assign tick       = (pcnt == PW'(DIV - 1));
  assign last_digit = (idx == IW'(NUM_DIGITS - 1));
  assign in_guard   = (pcnt < PW'(GUARD));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_data  <= '0;
      sh_dp    <= '0;
      sh_blank <= '0;
    end else if (load) begin
      sh_data  <= data;
      sh_dp    <= dp;
      sh_blank <= blank;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt <= '0;
      idx  <= '0;
    end else if (tick) begin
      pcnt <= '0;
      idx  <= last_digit ? '0 : idx + 1'b1;
    end else begin
      pcnt <= pcnt + 1'b1;
    end
  end

  // Walk from the most significant digit down: lz_run stays set only while
  // every digit so far is a zero nibble without a lit dp. Digit 0 is exempt.
  always_comb begin
    dark   = '0;
    lz_run = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      lz_run  = lz_run & (sh_data[4*i +: 4] == 4'h0) & ~sh_dp[i];
      dark[i] = sh_blank[i] | (lz_en & lz_run & (i != 0));
    end
  end

  always_comb begin
    cur_nib  = '0;
    cur_dp   = 1'b0;
    cur_dark = 1'b1;
    an_sel   = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IW'(i)) begin
        cur_nib   = sh_data[4*i +: 4];
        cur_dp    = sh_dp[i];
        cur_dark  = dark[i];
        an_sel[i] = 1'b1;
      end
    end
  end

  seven_seg_hex u_hex (
    .nib (cur_nib),
    .pat (cur_pat)
  );

  // Active-high next values; polarity is applied at the output registers.
  always_comb begin
    seg_h_nxt = SEG_OFF_H;
    dp_h_nxt  = 1'b0;
    an_h_nxt  = '0;
    if (!in_guard) begin
      an_h_nxt = an_sel;
      if (!cur_dark) begin
        seg_h_nxt = cur_pat;
        dp_h_nxt  = cur_dp;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg        <= seg_polarity(SEG_OFF_H, SEG_ACTIVE_LOW);
      dp_out     <= SEG_ACTIVE_LOW;
      an         <= {NUM_DIGITS{AN_ACTIVE_LOW}};
      frame_done <= 1'b0;
    end else begin
      seg        <= seg_polarity(seg_h_nxt, SEG_ACTIVE_LOW);
      dp_out     <= dp_h_nxt ^ SEG_ACTIVE_LOW;
      an         <= an_h_nxt ^ {NUM_DIGITS{AN_ACTIVE_LOW}};
      frame_done <= tick & last_digit;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan.sv
module tb_seven_seg_scan;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] data;
  logic [3:0]  dp;
  logic [3:0]  blank;
  logic        lz_en;
  logic        load;
  logic [6:0]  seg;
  logic        dp_out;
  logic [3:0]  an;
  logic        frame_done;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  seven_seg_scan #(
    .NUM_DIGITS     (4),
    .CLK_HZ         (16),
    .SCAN_HZ        (2),
    .GUARD          (2),
    .SEG_ACTIVE_LOW (1'b1),
    .AN_ACTIVE_LOW  (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .data       (data),
    .dp         (dp),
    .blank      (blank),
    .lz_en      (lz_en),
    .load       (load),
    .seg        (seg),
    .dp_out     (dp_out),
    .an         (an),
    .frame_done (frame_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " seg"}, 32'(seg), 32'h7F);
    chk({tag, " dp_out"}, 32'(dp_out), 32'h1);
    chk({tag, " an"}, 32'(an), 32'hF);
    chk({tag, " frame_done"}, 32'(frame_done), 32'h0);
  endtask

  // Checks one full frame (4 digits x 8 cycles). Must be entered at the
  // negedge just before the edge where the scan sits at digit 0, pcnt 0.
  // es/edp are pin-level (active-low) expected seg and dp_out per digit.
  task automatic frame(input string tag,
                       input logic [6:0] s3, input logic [6:0] s2,
                       input logic [6:0] s1, input logic [6:0] s0,
                       input logic [3:0] edp, input bit drop_load);
    logic [6:0] es [4];
    logic [3:0] ean;
    es = '{s0, s1, s2, s3};
    for (int d = 0; d < 4; d++) begin
      for (int p = 0; p < 8; p++) begin
        @(negedge clk);
        if (drop_load && d == 0 && p == 0) load = 1'b0;
        if (p < 2) begin
          chk($sformatf("%s d%0d p%0d an", tag, d, p), 32'(an), 32'hF);
          chk($sformatf("%s d%0d p%0d seg", tag, d, p), 32'(seg), 32'h7F);
          chk($sformatf("%s d%0d p%0d dp", tag, d, p), 32'(dp_out), 32'h1);
        end else begin
          ean = 4'hF;
          ean[d] = 1'b0;
          chk($sformatf("%s d%0d p%0d an", tag, d, p), 32'(an), 32'(ean));
          chk($sformatf("%s d%0d p%0d seg", tag, d, p), 32'(seg), 32'(es[d]));
          chk($sformatf("%s d%0d p%0d dp", tag, d, p), 32'(dp_out), 32'(edp[d]));
        end
        chk($sformatf("%s d%0d p%0d fd", tag, d, p), 32'(frame_done),
            (d == 3 && p == 7) ? 32'h1 : 32'h0);
      end
    end
  endtask

  initial begin
    rst   = 1'b1;
    data  = 16'h1234;
    dp    = 4'b0000;
    blank = 4'b0000;
    lz_en = 1'b0;
    load  = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset("reset");

    // Reset release; shadow captures 1234 at the first edge (inside guard).
    rst = 1'b0;
    frame("hex1234_f0", 7'h79, 7'h24, 7'h30, 7'h19, 4'hF, 1'b0);
    frame("hex1234_f1", 7'h79, 7'h24, 7'h30, 7'h19, 4'hF, 1'b0);

    // Leading-zero suppression stops at the first non-zero digit.
    lz_en = 1'b1;
    data  = 16'h0050;
    frame("lz0050", 7'h7F, 7'h7F, 7'h12, 7'h40, 4'hF, 1'b0);

    // A lit dp stops suppression at its digit.
    data = 16'h0000;
    dp   = 4'b0100;
    frame("lz_dp", 7'h7F, 7'h40, 7'h40, 7'h40, 4'b1011, 1'b0);

    // Shadow isolation: data changes without load leave the display alone.
    lz_en = 1'b0;
    dp    = 4'b0000;
    data  = 16'h1111;
    frame("d1111", 7'h79, 7'h79, 7'h79, 7'h79, 4'hF, 1'b0);
    data = 16'h2222;
    load = 1'b0;
    frame("noload", 7'h79, 7'h79, 7'h79, 7'h79, 4'hF, 1'b0);
    load = 1'b1;
    frame("pulse", 7'h24, 7'h24, 7'h24, 7'h24, 4'hF, 1'b1);
    data = 16'h3333;
    frame("held", 7'h24, 7'h24, 7'h24, 7'h24, 4'hF, 1'b0);

    // Forced blanking.
    data  = 16'hFFFF;
    blank = 4'b1010;
    load  = 1'b1;
    frame("blank", 7'h7F, 7'h0E, 7'h7F, 7'h0E, 4'hF, 1'b0);

    // Reset in the middle of digit 2's lit window.
    repeat (19) @(negedge clk);
    chk("mid d2 an", 32'(an), 32'hB);
    chk("mid d2 seg", 32'(seg), 32'h0E);
    #1 rst = 1'b1;
    #1 chk_reset("async_rst");
    @(negedge clk);
    chk_reset("rst_held");
    load  = 1'b0;
    blank = 4'b0000;
    rst   = 1'b0;
    // Shadow was cleared, so every digit shows "0", scanning from digit 0.
    frame("postrst", 7'h40, 7'h40, 7'h40, 7'h40, 4'hF, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
